// File: rtl/mat_row_packer.sv
// mat_row_packer
// Packs a word-serial stream of DATA_LEN-bit matrix elements into rows of N
// lanes (element k of a row in bits [DATA_LEN*k +: DATA_LEN]) and writes the
// M rows of one matrix to consecutive row-memory addresses starting at
// i_base_addr. The address wraps modulo 2^ADDRESS_SIZE. o_done pulses for one
// cycle once the last row has been written.
//
// Ports:
//   i_clk, i_rst          clock (rising edge), asynchronous active-high reset
//   i_start, i_base_addr  begin a load at the given first row address (IDLE only)
//   i_valid, o_ready      element handshake; i_data is the element
//   i_last                end-of-matrix marker (checked only with the macro below)
//   o_address, o_write_data, o_wr_en   row memory write port
//   o_busy, o_done, o_err              status
//
// Configuration macro: MAT_ROW_PACKER_LAST_CHECK_EN
//   defined   : i_last is checked on every handshake; a mismatch sets the
//               sticky o_err until the next accepted start or reset.
//   undefined : i_last is ignored and o_err is tied to 0.
//
// All outputs come from registers or from the state decode, so there is no
// combinational path from the stream inputs to any output.

module mat_row_packer #(
    parameter int DATA_LEN     = 32,
    parameter int N            = 8,
    parameter int M            = 8,
    parameter int ADDRESS_SIZE = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [ADDRESS_SIZE-1:0] i_base_addr,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [DATA_LEN-1:0]     i_data,
    input  logic                    i_last,
    output logic [ADDRESS_SIZE-1:0] o_address,
    output logic [DATA_LEN*N-1:0]   o_write_data,
    output logic                    o_wr_en,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err
);

    // state | meaning
    // IDLE  | waiting for i_start
    // FILL  | accepting elements into the lanes of the current row
    // WRITE | one-cycle write of the packed row
    // DONE  | one-cycle o_done pulse, then back to IDLE
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int LANE_W = (N > 1) ? $clog2(N) : 1;
    localparam int ROW_W  = (M > 1) ? $clog2(M) : 1;

    state_t                  state_q;
    state_t                  state_d;
    logic [LANE_W-1:0]       lane_cnt;
    logic [ROW_W-1:0]        row_cnt;
    logic [ADDRESS_SIZE-1:0] addr_q;
    logic [DATA_LEN*N-1:0]   row_q;
    logic                    handshake;
    logic                    lane_last;
    logic                    row_last;

    assign handshake = i_valid && (state_q == S_FILL);
    assign lane_last = (lane_cnt == LANE_W'(N - 1));
    assign row_last  = (row_cnt == ROW_W'(M - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_start) state_d = S_FILL;
            S_FILL:  if (handshake && lane_last) state_d = S_WRITE;
            S_WRITE: state_d = row_last ? S_DONE : S_FILL;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lane_cnt <= '0;
            row_cnt  <= '0;
            addr_q   <= '0;
            row_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        addr_q   <= i_base_addr;
                        lane_cnt <= '0;
                        row_cnt  <= '0;
                    end
                end
                S_FILL: begin
                    if (handshake) begin
                        // Only the addressed lane changes; the other lanes keep
                        // whatever they held from the previous row.
                        for (int k = 0; k < N; k++) begin
                            if (lane_cnt == LANE_W'(k)) begin
                                row_q[k*DATA_LEN +: DATA_LEN] <= i_data;
                            end
                        end
                        lane_cnt <= lane_last ? '0 : lane_cnt + LANE_W'(1);
                    end
                end
                S_WRITE: begin
                    if (!row_last) begin
                        row_cnt  <= row_cnt + ROW_W'(1);
                        addr_q   <= addr_q + ADDRESS_SIZE'(1);
                        lane_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MAT_ROW_PACKER_LAST_CHECK_EN
    logic err_q;
    logic last_expected;

    // i_last must be high exactly on the final lane of the final row.
    assign last_expected = lane_last && row_last;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            err_q <= 1'b0;
        end else if (state_q == S_IDLE && i_start) begin
            err_q <= 1'b0;
        end else if (handshake && (i_last != last_expected)) begin
            err_q <= 1'b1;
        end
    end

    assign o_err = err_q;
`else
    logic unused_last;
    assign unused_last = i_last;
    assign o_err       = 1'b0;
`endif

    assign o_ready      = (state_q == S_FILL);
    assign o_wr_en      = (state_q == S_WRITE);
    assign o_busy       = (state_q != S_IDLE);
    assign o_done       = (state_q == S_DONE);
    assign o_address    = addr_q;
    assign o_write_data = row_q;

endmodule

// File: tb/tb_mat_row_packer.sv
// Self-checking bench for mat_row_packer. Each load's expected row writes are
// computed from the element list and queued before streaming; a negedge
// monitor pops and compares whenever o_wr_en is seen.

module tb_mat_row_packer;

    localparam int DL = 32;
    localparam int NN = 8;
    localparam int MM = 8;
    localparam int AW = 4;
    localparam int NE = NN * MM;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_start = 1'b0;
    logic [AW-1:0]     i_base_addr = '0;
    logic              i_valid = 1'b0;
    logic              o_ready;
    logic [DL-1:0]     i_data = '0;
    logic              i_last = 1'b0;
    logic [AW-1:0]     o_address;
    logic [DL*NN-1:0]  o_write_data;
    logic              o_wr_en;
    logic              o_busy;
    logic              o_done;
    logic              o_err;

    mat_row_packer #(.DATA_LEN(DL), .N(NN), .M(MM), .ADDRESS_SIZE(AW)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_base_addr  (i_base_addr),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_data       (i_data),
        .i_last       (i_last),
        .o_address    (o_address),
        .o_write_data (o_write_data),
        .o_wr_en      (o_wr_en),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [DL*NN-1:0] data;
    } wr_t;

    wr_t        exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         start_cyc = 0;
    int         done_cyc = 0;
    int         done_cnt = 0;
    logic       prev_wr = 1'b0;
    logic [DL-1:0] elems[NE];

    task automatic chk(input string name, input logic [DL*NN-1:0] act,
                       input logic [DL*NN-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(posedge i_clk) cyc++;

    // Monitor / scoreboard
    always @(negedge i_clk) begin
        if (i_rst) begin
            chk("reset_outputs_zero",
                {o_ready, o_wr_en, o_busy, o_done, o_err, o_address, o_write_data}, '0);
        end
        if (o_wr_en) begin
            chk("wr_one_cycle", prev_wr, 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_address", o_address, e.addr);
                chk("wr_data", o_write_data, e.data);
            end
        end
        prev_wr = o_wr_en;
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // Reference: row r holds elements r*N .. r*N+N-1, lane k = element r*N+k,
    // written at (base + r) mod 2^AW. Only complete rows are ever written.
    task automatic push_expected(input logic [AW-1:0] base, input int n_elems);
        for (int r = 0; r < n_elems / NN; r++) begin
            wr_t e;
            e.addr = AW'((int'(base) + r) % (1 << AW));
            e.data = '0;
            for (int k = 0; k < NN; k++) e.data[k*DL +: DL] = elems[r*NN + k];
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset(input int cycles);
        i_rst = 1'b1;
        i_valid = 1'b0;
        i_start = 1'b0;
        repeat (cycles) @(posedge i_clk);
        #1 i_rst = 1'b0;
    endtask

    // mode: 0 data=index, 1 data=2*index, 2 random data.
    // bad_last: element index carrying a spurious i_last (-1 = none).
    task automatic do_load(input logic [AW-1:0] base, input int gap_pct, input int mode,
                           input int n_elems, input int bad_last, input bit mid_start,
                           input bit start_valid, input bit check_lat);
        int idx;
        int guard;
        int d0;
        int w;
        bit acc;
        bit exp_err;
        for (int i = 0; i < NE; i++)
            elems[i] = (mode == 0) ? DL'(i) : (mode == 1) ? DL'(2 * i) : $urandom;
        push_expected(base, n_elems);
`ifdef MAT_ROW_PACKER_LAST_CHECK_EN
        exp_err = (bad_last >= 0) && (bad_last != NE - 1);
`else
        exp_err = 1'b0;
`endif
        d0 = done_cnt;
        // start cycle (optionally with a competing element that must be refused)
        i_start = 1'b1;
        i_base_addr = base;
        i_valid = start_valid;
        i_data = 32'hDEAD_BEEF;
        i_last = 1'b0;
        @(posedge i_clk);
        #1;
        start_cyc = cyc;
        i_start = 1'b0;
        i_valid = 1'b0;
        chk("busy_after_start", o_busy, 1);
        chk("err_cleared_on_start", o_err, 0);
        idx = 0;
        guard = 0;
        while (idx < n_elems && guard < 2000) begin
            i_valid = ($urandom_range(99) >= gap_pct);
            i_data = elems[idx];
            i_last = (idx == NE - 1) || (idx == bad_last);
            if (mid_start && idx == 10) begin
                i_start = 1'b1;
                i_base_addr = ~base;
            end
            @(negedge i_clk);
            acc = i_valid && o_ready;
            @(posedge i_clk);
            #1;
            i_start = 1'b0;
            if (acc) idx++;
            guard++;
        end
        i_valid = 1'b0;
        i_last = 1'b0;
        if (guard >= 2000) chk("stream_timeout", 1, 0);
        if (n_elems < NE) return;
        w = 0;
        while (done_cnt == d0 && w < 300) begin
            @(posedge i_clk);
            #1;
            w++;
        end
        chk("done_seen", done_cnt - d0, 1);
        // o_done is high in the cycle closed by edge start + 1 + M*(N+1)
        if (check_lat) chk("done_latency", done_cyc - start_cyc + 1, MM * (NN + 1) + 1);
        @(posedge i_clk);
        #1;
        chk("idle_after_done", {o_busy, o_done, o_ready}, 0);
        chk("all_rows_written", exp_q.size(), 0);
        chk("err_after_load", o_err, exp_err);
    endtask

    initial begin
        do_reset(3);
        @(negedge i_clk);
        chk("post_reset_idle", {o_ready, o_wr_en, o_busy, o_done, o_err}, 0);
        @(posedge i_clk);
        #1;

        // continuous stream, base 0
        do_load(4'd0, 0, 0, NE, -1, 1'b0, 1'b0, 1'b1);
        // base 12 wraps through 15 -> 0
        do_load(4'd12, 0, 0, NE, -1, 1'b0, 1'b0, 1'b1);
        // ~50% valid gaps, data = 2*index
        do_load(4'd0, 50, 1, NE, -1, 1'b0, 1'b0, 1'b0);

        // abort after 20 elements: two full rows written, partial row discarded
        do_load(4'd3, 0, 0, 20, -1, 1'b0, 1'b0, 1'b0);
        do_reset(3);
        chk("abort_no_partial_write", exp_q.size(), 0);
        @(posedge i_clk);
        #1;
        chk("abort_idle", o_busy, 0);
        do_load(4'd0, 0, 2, NE, -1, 1'b0, 1'b0, 1'b1);

        // start with simultaneous element in IDLE, and start pulsed mid-fill
        do_load(4'd5, 30, 2, NE, -1, 1'b1, 1'b1, 1'b0);

        // spurious i_last on element 40, then a clean load
        do_load(4'd2, 0, 0, NE, 40, 1'b0, 1'b0, 1'b0);
        do_load(4'd9, 20, 2, NE, -1, 1'b0, 1'b0, 1'b0);

        for (int t = 0; t < 3; t++)
            do_load(AW'($urandom_range(15)), $urandom_range(60), 2, NE, -1,
                    1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge i_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
